// File: rtl/aes_key_schedule_ctrl_if.sv
// Request/status/read-port bundle between the AES-128 key-schedule sequencer
// and its client (the cipher round controller).
interface aes_key_schedule_ctrl_if;
  // start is a request qualified by busy: it is taken on a rising edge only while
  // busy is low, and keyIn is sampled on that edge alone. The read port has no
  // handshake: rdKey follows rdRound after the configured latency, and index r is
  // trustworthy once keysAvail >= r (index 0 from the cycle after acceptance).
  logic         start;
  logic [127:0] keyIn;
  logic         busy;
  logic         done;
  logic         keyValid;
  logic [3:0]   keysAvail;
  logic [3:0]   rdRound;
  logic [127:0] rdKey;

  modport master (
    output start, keyIn, rdRound,
    input  busy, done, keyValid, keysAvail, rdKey
  );

  modport slave (
    input  start, keyIn, rdRound,
    output busy, done, keyValid, keysAvail, rdKey
  );
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key expansion: one KeyExpansionRound reused for rounds 1..10,
// results held in an 11 x 128 round-key file with an indexed read port.
module aes_key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  aes_key_schedule_ctrl_if.slave        bus,
  output logic [1:0]                    dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset (255-b)*8, and 255-b is ~b for a byte.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] key_round(input logic [3:0] rnd, input logic [127:0] prev);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = prev[127:96];
    w1 = prev[95:64];
    w2 = prev[63:32];
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(rnd), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   avail_q, avail_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic [127:0] rk_q [0:10];

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;
  logic [127:0] prev_key;
  logic [127:0] round_key;

  // cnt is 0 only outside EXPAND, so the guard only keeps the index in range.
  always_comb begin
    prev_key = '0;
    if (cnt_q >= 4'd1 && cnt_q <= 4'd10) prev_key = rk_q[cnt_q - 4'd1];
    round_key = key_round(cnt_q, prev_key);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    avail_d = avail_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = round_key;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (bus.start) begin
          state_d = ST_EXPAND;
          cnt_d   = 4'd1;
          avail_d = 4'd0;
          valid_d = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = bus.keyIn;
        end
      end
      ST_EXPAND: begin
        wr_en   = 1'b1;
        avail_d = cnt_q;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LAST_ROUND) begin
          state_d = ST_READY;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      avail_q <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      avail_q <= avail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else if (wr_en) begin
      rk_q[wr_idx] <= wr_data;
    end
  end

  logic [127:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (bus.rdRound <= 4'd10) rd_mux = rk_q[bus.rdRound];
  end

  if (READ_LATENCY == 0) begin : g_rd_comb
    assign bus.rdKey = rd_mux;
  end else begin : g_rd_reg
    logic [127:0] rd_key_q;
    always_ff @(posedge clk) begin
      if (reset) rd_key_q <= '0;
      else       rd_key_q <= rd_mux;
    end
    assign bus.rdKey = rd_key_q;
  end

  assign bus.busy      = (state_q == ST_EXPAND);
  assign bus.done      = done_q;
  assign bus.keyValid  = valid_q;
  assign bus.keysAvail = avail_q;
  assign dbg_state_o   = state_q;

endmodule
